// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: datapath width, fetch FSM states, NOP encoding
// and the major opcodes used by fetch and control.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_FULL,
    S_DROP
  } fetch_state_t;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational redirect decision and target computation; kept standalone so
// the redirect point can later move to EX without touching fetch.
module branch_resolve
  import riscv_pkg::*;
(
  input  logic            i_branch_eq,
  input  logic            i_branch_ne,
  input  logic            i_branch_lt,
  input  logic            i_jump,
  input  logic            i_alu_zero,
  input  logic            i_alu_lt,
  input  logic [XLEN-1:0] i_branch_pc,
  input  logic [XLEN-1:0] i_imm,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_target
);

  logic [XLEN-1:0] w_sum;

  assign o_redirect = i_jump
                    | (i_branch_eq & i_alu_zero)
                    | (i_branch_ne & ~i_alu_zero)
                    | (i_branch_lt & i_alu_lt);

  assign w_sum    = i_branch_pc + i_imm;
  assign o_target = {w_sum[XLEN-1:1], 1'b0};

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: owns the PC, issues one outstanding imem request at
// a time, and feeds an IF/ID register backed by a one-entry skid buffer.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_eq,
  input  logic            branch_ne,
  input  logic            branch_lt,
  input  logic            jump,
  input  logic            alu_zero,
  input  logic            alu_lt,
  input  logic [XLEN-1:0] branch_pc,
  input  logic [XLEN-1:0] imm,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_inst,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc4
);

  fetch_state_t    r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic            r_skid_valid, w_skid_valid_nxt;
  logic [XLEN-1:0] r_skid_inst, w_skid_inst_nxt;
  logic            r_if_valid, w_if_valid_nxt;
  logic [XLEN-1:0] r_if_inst, w_if_inst_nxt;
  logic [XLEN-1:0] r_if_pc, w_if_pc_nxt;

  logic            w_redirect;
  logic [XLEN-1:0] w_target;
  logic            w_free;
  logic            w_load;
  logic [XLEN-1:0] w_load_inst;

  branch_resolve u_branch_resolve (
    .i_branch_eq (branch_eq),
    .i_branch_ne (branch_ne),
    .i_branch_lt (branch_lt),
    .i_jump      (jump),
    .i_alu_zero  (alu_zero),
    .i_alu_lt    (alu_lt),
    .i_branch_pc (branch_pc),
    .i_imm       (imm),
    .o_redirect  (w_redirect),
    .o_target    (w_target)
  );

  assign w_free = ~r_if_valid | ~stall;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_inst_nxt  = r_skid_inst;
    w_load           = 1'b0;
    w_load_inst      = r_skid_inst;

    case (r_state)
      S_REQ:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (imem_ready) begin
          if (w_free) begin
            w_load      = 1'b1;
            w_load_inst = imem_rdata;
            w_pc_nxt    = pc_plus4(r_pc);
            w_state_nxt = S_REQ;
          end else begin
            w_skid_valid_nxt = 1'b1;
            w_skid_inst_nxt  = imem_rdata;
            w_state_nxt      = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (!stall && r_skid_valid) begin
          w_load           = 1'b1;
          w_load_inst      = r_skid_inst;
          w_skid_valid_nxt = 1'b0;
          w_pc_nxt         = pc_plus4(r_pc);
          w_state_nxt      = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_ready) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_REQ;
    endcase

    // Redirect overrides whatever the state logic decided above; only a
    // request still in flight needs the S_DROP detour.
    if (w_redirect) begin
      w_load           = 1'b0;
      w_pc_nxt         = w_target;
      w_skid_valid_nxt = 1'b0;
      if (r_state == S_REQ || (r_state == S_WAIT && !imem_ready))
        w_state_nxt = S_DROP;
      else
        w_state_nxt = S_REQ;
    end
  end

  always_comb begin
    w_if_valid_nxt = r_if_valid;
    w_if_inst_nxt  = r_if_inst;
    w_if_pc_nxt    = r_if_pc;
    if (w_redirect) begin
      w_if_valid_nxt = 1'b0;
    end else if (w_load) begin
      w_if_valid_nxt = 1'b1;
      w_if_inst_nxt  = w_load_inst;
      w_if_pc_nxt    = r_pc;
    end else if (!stall) begin
      w_if_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_skid_valid <= 1'b0;
      r_skid_inst  <= NOP_INST;
      r_if_valid   <= 1'b0;
      r_if_inst    <= NOP_INST;
      r_if_pc      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_inst  <= w_skid_inst_nxt;
      r_if_valid   <= w_if_valid_nxt;
      r_if_inst    <= w_if_inst_nxt;
      r_if_pc      <= w_if_pc_nxt;
    end
  end

  assign imem_req  = (r_state == S_REQ) & ~rst;
  assign imem_addr = r_pc;
  assign if_valid  = r_if_valid;
  assign if_inst   = r_if_inst;
  assign if_pc     = r_if_pc;
  assign if_pc4    = pc_plus4(r_if_pc);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written redirect/wrap/reset
// sequences, then random stall/redirect traffic against a program-order model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic        branch_eq, branch_ne, branch_lt, jump, alu_zero, alu_lt;
  logic [31:0] branch_pc, imm;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_inst, if_pc, if_pc4;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .branch_eq  (branch_eq),
    .branch_ne  (branch_ne),
    .branch_lt  (branch_lt),
    .jump       (jump),
    .alu_zero   (alu_zero),
    .alu_lt     (alu_lt),
    .branch_pc  (branch_pc),
    .imm        (imm),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_inst    (if_inst),
    .if_pc      (if_pc),
    .if_pc4     (if_pc4)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  int          pend;
  logic [31:0] paddr;
  logic [31:0] salt;
  int          fixed_lat;
  bit          rand_lat;
  bit          stale;

  typedef struct {
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(logic s, logic rq, logic [31:0] a, logic v,
                              logic [31:0] i, logic [31:0] p);
    vec_t r;
    r.stall = s; r.req = rq; r.addr = a; r.valid = v; r.inst = i; r.pc = p;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: response pulse for the pending request; returns addr^salt.
  task automatic mem_resp();
    if (pend > 0) begin
      pend--;
      imem_ready = (pend == 0);
      imem_rdata = (pend == 0) ? (paddr ^ salt) : 32'hDEAD_BEEF;
    end else begin
      imem_ready = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
    end
  endtask

  task automatic pre_mid();
    mem_resp();
    #1;
  endtask

  task automatic post();
    if (imem_req) begin
      pend  = rand_lat ? int'($urandom_range(1, 3)) : fixed_lat;
      paddr = imem_addr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      pre_mid();
      post();
    end
  endtask

  task automatic clear_ctl();
    branch_eq = 0; branch_ne = 0; branch_lt = 0; jump = 0;
    alu_zero = 0; alu_lt = 0; branch_pc = '0; imm = '0;
  endtask

  task automatic do_reset(input int lat);
    rst = 1'b1; stall = 1'b0; clear_ctl();
    pend = 0; stale = 0; fixed_lat = lat;
    run(2);
    rst = 1'b0;
  endtask

  logic [31:0] exp_pc;
  int          consumed;
  bit          redir, seen;
  logic [31:0] tgt;

  initial begin
    rst = 1'b1; stall = 1'b0; clear_ctl();
    imem_ready = 1'b0; imem_rdata = '0;
    pend = 0; paddr = '0; salt = '0; fixed_lat = 1; rand_lat = 0; stale = 0;

    // Latency-1 stream, then a 5-cycle stall while a response lands.
    tbl[0]  = mk(0, 1, 32'h00, 0, 32'h13, 32'h00);
    tbl[1]  = mk(0, 0, 32'h00, 0, 32'h13, 32'h00);
    tbl[2]  = mk(0, 1, 32'h04, 1, 32'h00, 32'h00);
    tbl[3]  = mk(0, 0, 32'h04, 0, 32'h00, 32'h00);
    tbl[4]  = mk(0, 1, 32'h08, 1, 32'h04, 32'h04);
    tbl[5]  = mk(0, 0, 32'h08, 0, 32'h04, 32'h04);
    tbl[6]  = mk(0, 1, 32'h0C, 1, 32'h08, 32'h08);
    tbl[7]  = mk(1, 0, 32'h0C, 0, 32'h08, 32'h08);
    tbl[8]  = mk(1, 1, 32'h10, 1, 32'h0C, 32'h0C);
    tbl[9]  = mk(1, 0, 32'h10, 1, 32'h0C, 32'h0C);
    tbl[10] = mk(1, 0, 32'h10, 1, 32'h0C, 32'h0C);
    tbl[11] = mk(1, 0, 32'h10, 1, 32'h0C, 32'h0C);
    tbl[12] = mk(0, 0, 32'h10, 1, 32'h0C, 32'h0C);
    tbl[13] = mk(0, 1, 32'h14, 1, 32'h10, 32'h10);
    tbl[14] = mk(0, 0, 32'h14, 0, 32'h10, 32'h10);

    do_reset(1);
    chk("reset_if_pc4", if_pc4, 32'h4);
    chk("reset_if_inst", if_inst, 32'h13);
    for (int i = 0; i < 15; i++) begin
      stall = tbl[i].stall;
      pre_mid();
      chk($sformatf("tbl%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].req});
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), {31'b0, if_valid}, {31'b0, tbl[i].valid});
      if (tbl[i].valid) begin
        chk($sformatf("tbl%0d_inst", i), if_inst, tbl[i].inst);
        chk($sformatf("tbl%0d_pc", i), if_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_pc4", i), if_pc4, tbl[i].pc + 32'd4);
      end
      post();
    end
    stall = 0;

    // Branch-ne not taken, then taken branch-eq with stall held high.
    do_reset(1);
    run(2);
    branch_ne = 1; alu_zero = 1; branch_pc = 32'h40; imm = 32'hFFFF_FFF0;
    run(1); clear_ctl();
    run(1);
    branch_eq = 1; alu_zero = 1; branch_pc = 32'h40; imm = 32'hFFFF_FFF0; stall = 1;
    pre_mid();
    chk("bne_not_taken_addr", imem_addr, 32'h08);
    chk("bne_not_taken_valid", {31'b0, if_valid}, 32'h1);
    post(); clear_ctl(); stall = 0;
    pre_mid();
    chk("beq_flush_valid", {31'b0, if_valid}, 32'h0);
    post();
    pre_mid();
    chk("beq_target_req", {31'b0, imem_req}, 32'h1);
    chk("beq_target_addr", imem_addr, 32'h30);
    post();
    run(1);
    pre_mid();
    chk("beq_first_valid", {31'b0, if_valid}, 32'h1);
    chk("beq_first_pc", if_pc, 32'h30);
    chk("beq_first_inst", if_inst, 32'h30);
    post();

    // Redirect with a latency-3 request outstanding.
    do_reset(3);
    run(1);
    jump = 1; branch_pc = 32'h100; imm = 32'h20;
    run(1); clear_ctl();
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      pre_mid();
      if (if_valid) begin
        seen = 1;
        chk("lat3_first_pc", if_pc, 32'h120);
        chk("lat3_first_inst", if_inst, 32'h120);
      end
      post();
    end
    chk("lat3_valid_seen", {31'b0, seen}, 32'h1);

    // PC wrap at 2^32 and jump target overflow with bit 0 cleared.
    do_reset(1);
    jump = 1; branch_pc = 32'hFFFF_FFF0; imm = 32'h0000_000C;
    run(1); clear_ctl();
    run(1);
    pre_mid();
    chk("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
    post();
    run(1);
    jump = 1; branch_pc = 32'hFFFF_FFF0; imm = 32'h0000_0019;
    pre_mid();
    chk("wrap_zero_addr", imem_addr, 32'h0);
    chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_if_pc4", if_pc4, 32'h0);
    post(); clear_ctl();
    run(1);
    pre_mid();
    chk("jump_ovf_addr", imem_addr, 32'h08);
    post();

    // Reset while parked in S_FULL with stall asserted.
    do_reset(1);
    run(2);
    stall = 1;
    run(2);
    pre_mid();
    chk("full_no_req", {31'b0, imem_req}, 32'h0);
    chk("full_inst_held", if_inst, 32'h0);
    post();
    rst = 1;
    run(1);
    rst = 0;
    pre_mid();
    chk("rst_full_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_full_req", {31'b0, imem_req}, 32'h1);
    chk("rst_full_addr", imem_addr, 32'h0);
    post();
    stall = 0;

    // Random traffic: decode must see consecutive PCs, restarting at each target.
    salt = 32'h5A5A_0000; rand_lat = 1;
    do_reset(1);
    exp_pc = 32'h0; consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      mem_resp();
      if (imem_ready) stale = 0;
      stall     = ($urandom_range(0, 9) < 3);
      branch_eq = ($urandom_range(0, 7) == 0);
      branch_ne = ($urandom_range(0, 7) == 0);
      branch_lt = ($urandom_range(0, 7) == 0);
      jump      = ($urandom_range(0, 31) == 0);
      alu_zero  = 1'($urandom_range(0, 1));
      alu_lt    = 1'($urandom_range(0, 1));
      branch_pc = $urandom;
      imm       = $urandom;
      redir = jump || (branch_eq && alu_zero) || (branch_ne && !alu_zero) ||
              (branch_lt && alu_lt);
      if (redir && stale) begin
        clear_ctl();
        redir = 0;
      end
      tgt = (branch_pc + imm) & 32'hFFFF_FFFE;
      #1;
      if (if_valid && !stall) begin
        chk("rand_pc", if_pc, exp_pc);
        chk("rand_inst", if_inst, exp_pc ^ salt);
        consumed++;
        exp_pc = exp_pc + 32'd4;
      end
      if (redir) exp_pc = tgt;
      if (imem_req && pend > 0) chk("rand_single_outstanding", 32'h1, 32'h0);
      post();
      if (redir && pend > 0) stale = 1;
    end
    clear_ctl(); stall = 0;
    chk("rand_progress", {31'b0, consumed > 100}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
